instruction_fetch_queue: RTL and testbench

Front-end stage that generates the word-addressed program counter, fetches instructions from a synchronous instruction memory, and buffers them with their PC in a small circular FIFO. It sits directly upstream of the dispatch unit. It presents the FIFO head as `Instruction` / `PC_out` and pops one entry per `Read_enable`. It redirects and flushes on `jump_branch_valid`.

---
 rtl/instruction_fetch_queue.sv | 109 ++++++++++
 tb/tb_instruction_fetch_queue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_queue.sv
// rtl/instruction_fetch_queue.sv - PC generation, synchronous instruction fetch and PC-tagged fetch FIFO
module instruction_fetch_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0010_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INST   = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_en,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  Read_enable,
  input  logic                  jump_branch_valid,
  input  logic [DATA_WIDTH-1:0] jump_branch_address,
  output logic [DATA_WIDTH-1:0] Instruction,
  output logic [DATA_WIDTH-1:0] PC_out,
  output logic                  empty,
  output logic                  full
);

  localparam int              PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CNT_W     = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]  DEPTH_OCC = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0]   pc_q, pc_d;
  logic                    inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0]   inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [2*DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [CNT_W:0]          occupancy;
  logic                    issue;
  logic                    wr_en;
  logic                    rd_en;
  logic [2*DATA_WIDTH-1:0] head;

  // Occupancy counts the in-flight fetch so a returning word always has a slot.
  always_comb begin
    occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    issue     = reset & ~jump_branch_valid & (occupancy < DEPTH_OCC);
    wr_en     = inflight_q & ~jump_branch_valid;
    rd_en     = Read_enable & (count_q != '0) & ~jump_branch_valid;

    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;

    if (jump_branch_valid) begin
      pc_d     = jump_branch_address;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = pc_q + DATA_WIDTH'(1);
      end
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage needs no reset: a slot is only read once count covers it.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {imem_rdata, inflight_pc_q};
  end

  always_comb begin
    head        = mem_q[rd_ptr_q];
    empty       = (count_q == '0);
    full        = (count_q == DEPTH_CNT);
    imem_en     = issue;
    imem_addr   = pc_q;
    Instruction = empty ? NOP_INST : head[2*DATA_WIDTH-1:DATA_WIDTH];
    PC_out      = empty ? '0 : head[DATA_WIDTH-1:0];
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb/tb_instruction_fetch_queue.sv - self-checking bench for instruction_fetch_queue
module tb_instruction_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0010_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] XOR_KEY  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        re;
  logic        jbv;
  logic [31:0] jba;
  logic [31:0] inst;
  logic [31:0] pc_out;
  logic        empty;
  logic        full;

  int          checks = 0;
  int          errors = 0;
  int          sb_pops = 0;
  logic [31:0] sb_q[$];
  logic [31:0] model_pc;

  typedef struct {
    logic        re;
    logic        e;
    logic        f;
    logic        en;
    logic [31:0] addr;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[15];

  always #5 clk = ~clk;

  // Synchronous memory: data for the address presented at an edge appears after it.
  always @(posedge clk) imem_rdata <= imem_addr ^ XOR_KEY;

  instruction_fetch_queue dut (
    .clk                 (clk),
    .reset               (reset),
    .imem_en             (imem_en),
    .imem_addr           (imem_addr),
    .imem_rdata          (imem_rdata),
    .Read_enable         (re),
    .jump_branch_valid   (jbv),
    .jump_branch_address (jba),
    .Instruction         (inst),
    .PC_out              (pc_out),
    .empty               (empty),
    .full                (full)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic sb_clear(input logic [31:0] pc);
    sb_q.delete();
    model_pc = pc;
  endtask

  // Called at the falling edge: records issued fetches, checks popped heads in order.
  task automatic sb_sample();
    logic [31:0] exp_pc;
    if (!reset) sb_clear(RESET_PC);
    else if (jbv) sb_clear(jba);
    else begin
      if (re && !empty) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_pop_unexpected actual=%h required=none", pc_out);
        end else begin
          exp_pc = sb_q.pop_front();
          chk("sb_pop_pc", pc_out, exp_pc);
          chk("sb_pop_inst", inst, exp_pc ^ XOR_KEY);
          sb_pops++;
        end
      end
      if (imem_en) begin
        chk("sb_fetch_addr", imem_addr, model_pc);
        sb_q.push_back(model_pc);
        model_pc = model_pc + 32'd1;
      end
    end
  endtask

  task automatic samp();
    @(negedge clk);
    sb_sample();
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string name, input logic exp_empty, input logic [31:0] exp_pc);
    chk({name, "_empty"}, 32'(empty), 32'(exp_empty));
    chk({name, "_pc"}, pc_out, exp_empty ? 32'h0 : exp_pc);
    chk({name, "_inst"}, inst, exp_empty ? NOP_INST : (exp_pc ^ XOR_KEY));
  endtask

  initial begin
    // re, empty, full, imem_en, imem_addr, head PC
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0010_0000, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0010_0001, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0010_0002, 32'h0010_0000};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0010_0003, 32'h0010_0000};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0010_0004, 32'h0010_0000};
    for (int i = 5; i < 10; i++)
      vecs[i] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0010_0004, 32'h0010_0000};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0010_0004, 32'h0010_0000};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0010_0004, 32'h0010_0001};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0010_0005, 32'h0010_0002};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0010_0006, 32'h0010_0003};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0010_0007, 32'h0010_0004};

    reset = 1'b0;
    re    = 1'b0;
    jbv   = 1'b0;
    jba   = '0;
    model_pc = RESET_PC;
    repeat (3) @(posedge clk);
    #1;
    chk_head("rst", 1'b1, 32'h0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_imem_en", 32'(imem_en), 32'd0);

    // Fill to full with no pops, then drain.
    sb_clear(RESET_PC);
    reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      re = vecs[i].re;
      samp();
      chk_head($sformatf("vec%0d", i), vecs[i].e, vecs[i].pc);
      chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].f));
      chk($sformatf("vec%0d_en", i), 32'(imem_en), 32'(vecs[i].en));
      chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].addr);
      cyc();
    end
    repeat (6) begin
      samp();
      cyc();
    end

    // Reset pulse between edges while a fetch is in flight.
    reset = 1'b0;
    re    = 1'b0;
    #1;
    chk_head("midrst", 1'b1, 32'h0);
    chk("midrst_full", 32'(full), 32'd0);
    chk("midrst_en", 32'(imem_en), 32'd0);
    #1;
    reset = 1'b1;
    sb_clear(RESET_PC);
    samp();
    chk_head("postrst_c0", 1'b1, 32'h0);
    chk("postrst_c0_addr", imem_addr, RESET_PC);
    chk("postrst_c0_en", 32'(imem_en), 32'd1);
    cyc();
    samp();
    chk_head("postrst_c1", 1'b1, 32'h0);
    cyc();
    samp();
    chk_head("postrst_c2", 1'b0, RESET_PC);
    cyc();
    samp();
    cyc();

    // Cycle 4: three entries held, one in flight; redirect with pop and response.
    jbv = 1'b1;
    jba = 32'h0010_0040;
    re  = 1'b1;
    samp();
    chk("redir_en", 32'(imem_en), 32'd0);
    chk("redir_full", 32'(full), 32'd0);
    cyc();
    jbv = 1'b0;
    samp();
    chk_head("redir_t1", 1'b1, 32'h0);
    chk("redir_t1_addr", imem_addr, 32'h0010_0040);
    chk("redir_t1_en", 32'(imem_en), 32'd1);
    cyc();
    samp();
    chk_head("redir_t2", 1'b1, 32'h0);
    cyc();
    samp();
    chk_head("redir_t3", 1'b0, 32'h0010_0040);
    cyc();
    samp();
    chk_head("redir_t4", 1'b0, 32'h0010_0041);
    cyc();

    // Back-to-back redirects; the second targets the top of the address space.
    jbv = 1'b1;
    jba = 32'h0000_0200;
    samp();
    cyc();
    jba = 32'hFFFF_FFFF;
    samp();
    cyc();
    jbv = 1'b0;
    samp();
    chk_head("wrap_t1", 1'b1, 32'h0);
    chk("wrap_t1_addr", imem_addr, 32'hFFFF_FFFF);
    cyc();
    samp();
    chk("wrap_t2_addr", imem_addr, 32'h0000_0000);
    cyc();
    samp();
    chk_head("wrap_t3", 1'b0, 32'hFFFF_FFFF);
    cyc();
    samp();
    chk_head("wrap_t4", 1'b0, 32'h0000_0000);
    cyc();

    // Random pop pattern checked only by the scoreboard.
    for (int i = 0; i < 40; i++) begin
      re = 1'($urandom_range(0, 1));
      samp();
      cyc();
    end
    re = 1'b1;
    repeat (8) begin
      samp();
      cyc();
    end

    chk("sb_pops_seen", 32'(sb_pops >= 10), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
